// File: rtl/instr_fetch_sequencer_pkg.sv
// rtl/instr_fetch_sequencer_pkg.sv - NN ISA control opcodes, default widths and sequencer state encoding
package instr_fetch_sequencer_pkg;

    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MEM_DEPTH = 128;

    localparam logic [7:0] ISA_OP_NOP  = 8'h00;
    localparam logic [7:0] ISA_OP_JUMP = 8'hFE;
    localparam logic [7:0] ISA_OP_HALT = 8'hFF;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH_OP  = 3'd1;
    localparam logic [2:0] ST_FETCH_ARG = 3'd2;
    localparam logic [2:0] ST_DISPATCH  = 3'd3;
    localparam logic [2:0] ST_HALTED    = 3'd4;

endpackage

// File: rtl/instr_fetch_sequencer.sv
// rtl/instr_fetch_sequencer.sv - PC owner and two-byte instruction fetch/dispatch sequencer
module instr_fetch_sequencer
    import instr_fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [DATA_W-1:0] OP_NOP     = DATA_W'(ISA_OP_NOP),
    parameter logic [DATA_W-1:0] OP_JUMP    = DATA_W'(ISA_OP_JUMP),
    parameter logic [DATA_W-1:0] OP_HALT    = DATA_W'(ISA_OP_HALT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_en,
    input  logic [DATA_W-1:0] ram_data,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_opcode,
    output logic [DATA_W-1:0] instr_operand,
    input  logic              instr_ready,
    output logic              busy,
    output logic              halted
);

    logic [2:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] jump_target;
    logic [DATA_W-1:0] opcode_reg;
    logic [DATA_W-1:0] operand_reg;

    // PC never leaves [0, MEM_DEPTH), so wrapping only needs to catch the last word
    always_comb begin
        pc_inc = pc + 1'b1;
        if (pc == ADDR_W'(MEM_DEPTH - 1)) begin
            pc_inc = '0;
        end
        jump_target = ADDR_W'(32'(ram_data) % MEM_DEPTH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            pc          <= START_ADDR;
            opcode_reg  <= '0;
            operand_reg <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_FETCH_OP;
                        pc    <= START_ADDR;
                    end
                end
                ST_FETCH_OP: begin
                    opcode_reg <= ram_data;
                    pc         <= pc_inc;
                    state      <= ST_FETCH_ARG;
                end
                ST_FETCH_ARG: begin
                    // Decode uses the live RAM word as operand so control ops cost no extra cycle
                    operand_reg <= ram_data;
                    pc          <= pc_inc;
                    if (opcode_reg == OP_NOP) begin
                        state <= ST_FETCH_OP;
                    end else if (opcode_reg == OP_JUMP) begin
                        pc    <= jump_target;
                        state <= ST_FETCH_OP;
                    end else if (opcode_reg == OP_HALT) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                    end else begin
                        state       <= ST_DISPATCH;
                        instr_valid <= 1'b1;
                    end
                end
                ST_DISPATCH: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= ST_FETCH_OP;
                    end
                end
                ST_HALTED: begin
                    if (start) begin
                        state  <= ST_FETCH_OP;
                        pc     <= START_ADDR;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram_addr      = pc;
    assign ram_en        = (state == ST_FETCH_OP) || (state == ST_FETCH_ARG);
    assign busy          = (state != ST_IDLE) && (state != ST_HALTED);
    assign instr_opcode  = opcode_reg;
    assign instr_operand = operand_reg;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb/tb_instr_fetch_sequencer.sv - directed and randomized bench for instr_fetch_sequencer
module tb_instr_fetch_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       instr_ready;
    logic [7:0] ram_addr;
    logic [7:0] ram_data;
    logic [7:0] instr_opcode;
    logic [7:0] instr_operand;
    logic       ram_en;
    logic       instr_valid;
    logic       busy;
    logic       halted;

    logic [7:0] mem [0:127];

    int checks = 0;
    int errors = 0;

    logic [7:0] got_op[$];
    logic [7:0] got_arg[$];
    logic [7:0] got_next[$];
    logic [7:0] exp_op[$];
    logic [7:0] exp_arg[$];
    logic [7:0] exp_next[$];
    bit         exp_halted;

    always #5 clk = ~clk;

    // Bus is undriven outside fetch; feed junk so any misuse shows up
    assign ram_data = ram_en ? mem[ram_addr[6:0]] : 8'hA5;

    instr_fetch_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ram_addr     (ram_addr),
        .ram_en       (ram_en),
        .ram_data     (ram_data),
        .instr_valid  (instr_valid),
        .instr_opcode (instr_opcode),
        .instr_operand(instr_operand),
        .instr_ready  (instr_ready),
        .busy         (busy),
        .halted       (halted)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < 128; i++) mem[i] = v;
    endtask

    // Interpret the program: each instruction is the word pair at pc, pc+1 (mod 128)
    task automatic model(input int limit);
        int         pc;
        logic [7:0] op;
        logic [7:0] arg;
        int         npc;
        pc = 0;
        exp_halted = 1'b0;
        exp_op.delete();
        exp_arg.delete();
        exp_next.delete();
        for (int s = 0; s < limit; s++) begin
            op  = mem[pc];
            arg = mem[(pc + 1) % 128];
            npc = (pc + 2) % 128;
            if (op == 8'hFF) begin
                exp_halted = 1'b1;
                break;
            end else if (op == 8'hFE) begin
                pc = int'(arg) % 128;
            end else if (op == 8'h00) begin
                pc = npc;
            end else begin
                exp_op.push_back(op);
                exp_arg.push_back(arg);
                exp_next.push_back(8'(npc));
                pc = npc;
            end
        end
    endtask

    task automatic run_program(input int budget, input bit rand_ready);
        int lowrun;
        bit pending_next;
        lowrun = 0;
        pending_next = 1'b0;
        got_op.delete();
        got_arg.delete();
        got_next.delete();
        reset = 1'b1;
        instr_ready = 1'b0;
        tick();
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < budget && !halted; c++) begin
            if (pending_next) begin
                got_next.push_back(ram_addr);
                pending_next = 1'b0;
            end
            if (rand_ready) begin
                instr_ready = (lowrun >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
                lowrun = instr_ready ? 0 : lowrun + 1;
            end else begin
                instr_ready = 1'b1;
            end
            if (instr_valid && instr_ready) begin
                got_op.push_back(instr_opcode);
                got_arg.push_back(instr_operand);
                pending_next = 1'b1;
            end
            tick();
        end
    endtask

    task automatic compare_run(input string tag);
        int n;
        if (exp_halted) begin
            check({tag, ":halted"}, 32'(halted), 32'd1);
            check({tag, ":count"}, got_op.size(), exp_op.size());
        end else begin
            check({tag, ":count_le"}, 32'(got_op.size() <= exp_op.size()), 32'd1);
        end
        n = (got_op.size() < exp_op.size()) ? got_op.size() : exp_op.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s:op%0d", tag, i), got_op[i], exp_op[i]);
            check($sformatf("%s:arg%0d", tag, i), got_arg[i], exp_arg[i]);
            if (i < got_next.size())
                check($sformatf("%s:next%0d", tag, i), got_next[i], exp_next[i]);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        instr_ready = 1'b0;
        fill_mem(8'hFF);

        // 1: reset for two cycles, then idle with no start
        tick();
        tick();
        check("rst:valid", 32'(instr_valid), 0);
        check("rst:busy", 32'(busy), 0);
        check("rst:halted", 32'(halted), 0);
        check("rst:ram_en", 32'(ram_en), 0);
        check("rst:addr", ram_addr, 0);
        check("rst:opcode", instr_opcode, 0);
        check("rst:operand", instr_operand, 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle:ram_en", 32'(ram_en), 0);
            check("idle:busy", 32'(busy), 0);
        end

        // 2: two dispatches then halt, ready held high
        mem[0] = 8'h02; mem[1] = 8'h05; mem[2] = 8'h03;
        mem[3] = 8'h07; mem[4] = 8'hFF; mem[5] = 8'h00;
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2:fop_en", 32'(ram_en), 1);
        check("t2:fop_addr", ram_addr, 0);
        check("t2:busy", 32'(busy), 1);
        tick();
        check("t2:farg_addr", ram_addr, 1);
        check("t2:farg_valid", 32'(instr_valid), 0);
        tick();
        check("t2:d1_valid", 32'(instr_valid), 1);
        check("t2:d1_op", instr_opcode, 8'h02);
        check("t2:d1_arg", instr_operand, 8'h05);
        check("t2:d1_en", 32'(ram_en), 0);
        tick();
        check("t2:f2_valid", 32'(instr_valid), 0);
        check("t2:f2_addr", ram_addr, 2);
        tick();
        tick();
        check("t2:d2_valid", 32'(instr_valid), 1);
        check("t2:d2_op", instr_opcode, 8'h03);
        check("t2:d2_arg", instr_operand, 8'h07);
        tick();
        tick();
        tick();
        check("t2:halted", 32'(halted), 1);
        check("t2:busy_off", 32'(busy), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2:halt_en", 32'(ram_en), 0);
            check("t2:halt_valid", 32'(instr_valid), 0);
        end

        // 3: restart from HALTED, stall dispatch, ignore start while busy
        fill_mem(8'hFF);
        mem[0] = 8'h02; mem[1] = 8'h05;
        instr_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t3:restart_addr", ram_addr, 0);
        check("t3:restart_halted", 32'(halted), 0);
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            tick();
            check("t3:hold_valid", 32'(instr_valid), 1);
            check("t3:hold_op", instr_opcode, 8'h02);
            check("t3:hold_arg", instr_operand, 8'h05);
            check("t3:hold_pc", ram_addr, 2);
        end
        start = 1'b0;
        instr_ready = 1'b1;
        tick();
        check("t3:xfer_valid", 32'(instr_valid), 0);
        tick();
        check("t3:no_second", 32'(instr_valid), 0);
        tick();
        check("t3:halted", 32'(halted), 1);

        // 4: NOP skipped, jump over a would-be dispatch, land at 6
        fill_mem(8'hFF);
        mem[0] = 8'h00; mem[1] = 8'h33; mem[2] = 8'hFE; mem[3] = 8'h06;
        mem[4] = 8'h02; mem[5] = 8'h44; mem[6] = 8'h02; mem[7] = 8'h09;
        model(2000);
        run_program(3000, 1'b1);
        compare_run("t4");
        check("t4:single", got_op.size(), 1);

        // 5: opcode at word 127 with its operand wrapped to word 0
        fill_mem(8'hFF);
        mem[0] = 8'h0A; mem[1] = 8'h7F; mem[2] = 8'hFE; mem[3] = 8'h7F;
        mem[127] = 8'h02;
        model(2000);
        run_program(3000, 1'b1);
        compare_run("t5");
        check("t5:wrap_next", 32'(got_next.size() > 1 && got_next[1] == 8'd1), 1);

        // 6: reset in DISPATCH with ready low drops the instruction
        fill_mem(8'hFF);
        mem[0] = 8'h02; mem[1] = 8'h05;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        instr_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("t6:pre_valid", 32'(instr_valid), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6:valid", 32'(instr_valid), 0);
        check("t6:busy", 32'(busy), 0);
        check("t6:pc", ram_addr, 0);
        check("t6:opcode", instr_opcode, 0);
        tick();
        check("t6:idle_en", 32'(ram_en), 0);
        check("t6:idle_busy", 32'(busy), 0);

        // Randomized programs against the interpreter
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 128; i++) begin
                int p;
                p = $urandom_range(0, 99);
                if (p < 6)       mem[i] = 8'hFF;
                else if (p < 14) mem[i] = 8'hFE;
                else if (p < 30) mem[i] = 8'h00;
                else             mem[i] = 8'($urandom_range(1, 253));
            end
            model(2000);
            run_program(3000, 1'b1);
            compare_run($sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
